riscv_wb_arbiter: RTL and testbench
===================================

// Module: riscv_wb_arbiter
// PURPOSE
// Writeback stage feeding the integer register file's single write port.
// Merges single-cycle ALU results and variable-latency load responses, formats load data
// (byte/half extraction, sign/zero extension) and tracks outstanding load destinations
// in a scoreboard so decode can stall on RAW hazards. All write-port outputs are registered.
// PARAMETERS
// MAX_PENDING  4                          max loads issued but not yet responded
// PCNT_W       $clog2(MAX_PENDING+1)      width of pending counter (derived, do not override)
// PORTS
// clock             in   1       core clock, all state on posedge
// reset             in   1       asynchronous, active-high
// alu_valid_i       in   1       ALU result valid
// alu_ready_o       out  1       arbiter can accept ALU result this cycle
// alu_rd_addr_i     in   5       ALU destination register
// alu_rd_data_i     in   32      ALU result
// ld_issue_i        in   1       load issued to LSU this cycle
// ld_issue_ready_o  out  1       load may be issued (pending < MAX_PENDING)
// ld_issue_rd_i     in   5       destination of issued load
// ld_rsp_valid_i    in   1       load response valid (always accepted, no backpressure)
// ld_rsp_rd_i       in   5       destination of responding load
// ld_rsp_data_i     in   32      raw aligned memory word
// ld_rsp_funct3_i   in   3       load type: 000 LB,001 LH,010 LW,100 LBU,101 LHU
// ld_rsp_addr_lo_i  in   2       byte address bits [1:0]
// rs1_addr_i        in   5       decode source 1 query
// rs2_addr_i        in   5       decode source 2 query
// rs1_busy_o        out  1       rs1 has outstanding load (combinational)
// rs2_busy_o        out  1       rs2 has outstanding load (combinational)
// pending_o         out  PCNT_W  count of outstanding loads
// rd_wen_o          out  1       register file write enable
// rd_addr_o         out  5       register file write address
// rd_data_o         out  32      register file write data
// BEHAVIOUR
// - Reset: rd_wen_o=0, rd_addr_o=0, rd_data_o=0, pending_o=0, scoreboard all clear,
//   skid empty, alu_ready_o=1, ld_issue_ready_o=1. Reset mid-operation drops skid and
//   all pending state; responses arriving after reset release are written but clear nothing.
// - Latency: accepted source -> rd_wen_o/rd_addr_o/rd_data_o registered, exactly 1 cycle.
// - Priority: load response > skid entry > live ALU. Load response is never stalled.
// - Skid: 1 entry. alu_ready_o = skid empty. ALU handshake = alu_valid_i & alu_ready_o.
//   If load response and accepted ALU collide, ALU captured in skid; skid drains on
//   first cycle without load response. While skid full alu_ready_o=0.
// - rd=0 writes: forwarded with rd_wen_o=0 (no write), handshake still completes.
// - Scoreboard busy[31:1]: set on ld_issue_i & ld_issue_ready_o & rd!=0; cleared when the
//   response for that rd is accepted. Same-cycle issue and response on same rd: set wins.
//   busy[0] constant 0. rsN_busy_o = busy[rsN_addr_i].
// - pending_o: +1 on accepted issue (incl. rd=0), -1 on response, both -> unchanged.
//   ld_issue_ready_o = pending_o < MAX_PENDING. Response at pending_o=0 does not underflow.
// - Load format: LB/LBU byte lane addr_lo; LH/LHU half lane addr_lo[1] (addr_lo[0] ignored);
//   LW full word; sign extend LB/LH, zero extend LBU/LHU; other funct3 -> raw word.
// - Upstream must not send ALU result to a busy rd; assertion flags it in simulation.
// TESTING
// - ALU rd=5 data 0x1234 alone -> next cycle rd_wen_o=1, rd_addr_o=5, rd_data_o=0x1234.
// - Collision: load rsp rd=3 LW 0xDEADBEEF + ALU rd=7 0x11 -> cycle1 x3=0xDEADBEEF,
//   alu_ready_o=0; cycle2 x7=0x11, alu_ready_o back to 1.
// - Formatting on word 0x80FF7F01: LB lo=3 -> 0xFFFFFF80; LBU lo=1 -> 0x7F;
//   LH lo=2 -> 0xFFFF80FF; LHU lo=0 -> 0x7F01; funct3=011 -> 0x80FF7F01.
// - Scoreboard: issue rd=9 -> rs1_addr_i=9 gives rs1_busy_o=1 same cycle after set; response
//   rd=9 -> busy clears; issue rd=0 -> pending_o=1, no busy bit.
// - Pending limit: 4 issues with no response -> ld_issue_ready_o=0, 5th issue ignored;
//   1 response -> pending_o=3, ready=1; simultaneous issue+response keeps pending_o.
// - Reset asserted with skid full and 2 pending -> all outputs zero, busy clear, ready=1.

Source files
------------

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter
// Writeback stage in front of the integer register file's single write port.
// It merges single-cycle ALU results with variable-latency load responses.
// It formats load data (byte/half extraction, sign/zero extension).
// It keeps a scoreboard of outstanding load destinations so decode can stall on RAW hazards.
//
// Ports:
//   clock, reset            core clock; asynchronous active-high reset
//   alu_valid_i/ready_o     ALU result handshake (alu_rd_addr_i, alu_rd_data_i)
//   ld_issue_i/ready_o      load issue to LSU (ld_issue_rd_i); ready while pending < MAX_PENDING
//   ld_rsp_*                load response (always accepted): rd, raw word, funct3, addr[1:0]
//   rs1/rs2_addr_i, *_busy_o  combinational scoreboard query from decode
//   pending_o               number of outstanding loads
//   rd_wen_o/addr_o/data_o  registered register-file write port
module riscv_wb_arbiter #(
  parameter  int MAX_PENDING = 4,
  localparam int PCNT_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [4:0]        alu_rd_addr_i,
  input  logic [31:0]       alu_rd_data_i,
  input  logic              ld_issue_i,
  output logic              ld_issue_ready_o,
  input  logic [4:0]        ld_issue_rd_i,
  input  logic              ld_rsp_valid_i,
  input  logic [4:0]        ld_rsp_rd_i,
  input  logic [31:0]       ld_rsp_data_i,
  input  logic [2:0]        ld_rsp_funct3_i,
  input  logic [1:0]        ld_rsp_addr_lo_i,
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic [PCNT_W-1:0] pending_o,
  output logic              rd_wen_o,
  output logic [4:0]        rd_addr_o,
  output logic [31:0]       rd_data_o
);

  localparam logic [PCNT_W-1:0] MAX_P = PCNT_W'(MAX_PENDING);

  logic              skid_vld_q, skid_vld_d;
  logic [4:0]        skid_rd_q, skid_rd_d;
  logic [31:0]       skid_data_q, skid_data_d;
  logic [31:0]       busy_q, busy_d;
  logic [PCNT_W-1:0] pend_q, pend_d;
  logic              wen_q, wen_d;
  logic [4:0]        addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              alu_acc, iss_acc;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    // Halfword lane picked by addr[1] only; misaligned halves are not split.
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  assign alu_ready_o      = ~skid_vld_q;
  assign ld_issue_ready_o = pend_q < MAX_P;
  assign alu_acc          = alu_valid_i & alu_ready_o;
  assign iss_acc          = ld_issue_i & ld_issue_ready_o;
  assign rs1_busy_o       = busy_q[rs1_addr_i];
  assign rs2_busy_o       = busy_q[rs2_addr_i];
  assign pending_o        = pend_q;
  assign rd_wen_o         = wen_q;
  assign rd_addr_o        = addr_q;
  assign rd_data_o        = data_q;

  always_comb begin
    skid_vld_d  = skid_vld_q;
    skid_rd_d   = skid_rd_q;
    skid_data_d = skid_data_q;
    wen_d       = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;

    // Load response owns the port; an ALU result accepted in the same cycle parks in
    // the skid (which is empty whenever an ALU result can be accepted).
    if (ld_rsp_valid_i) begin
      addr_d = ld_rsp_rd_i;
      data_d = fmt_load(ld_rsp_funct3_i, ld_rsp_addr_lo_i, ld_rsp_data_i);
      wen_d  = ld_rsp_rd_i != 5'd0;
      if (alu_acc) begin
        skid_vld_d  = 1'b1;
        skid_rd_d   = alu_rd_addr_i;
        skid_data_d = alu_rd_data_i;
      end
    end else if (skid_vld_q) begin
      addr_d     = skid_rd_q;
      data_d     = skid_data_q;
      wen_d      = skid_rd_q != 5'd0;
      skid_vld_d = 1'b0;
    end else if (alu_acc) begin
      addr_d = alu_rd_addr_i;
      data_d = alu_rd_data_i;
      wen_d  = alu_rd_addr_i != 5'd0;
    end

    // Clear before set so a same-cycle issue to the same rd leaves the bit set.
    busy_d = busy_q;
    if (ld_rsp_valid_i)                        busy_d[ld_rsp_rd_i]   = 1'b0;
    if (iss_acc && (ld_issue_rd_i != 5'd0))    busy_d[ld_issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;

    pend_d = pend_q;
    if (iss_acc && !ld_rsp_valid_i)                     pend_d = pend_q + PCNT_W'(1);
    else if (!iss_acc && ld_rsp_valid_i && pend_q != 0) pend_d = pend_q - PCNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skid_vld_q  <= 1'b0;
      skid_rd_q   <= 5'd0;
      skid_data_q <= 32'd0;
      busy_q      <= 32'd0;
      pend_q      <= '0;
      wen_q       <= 1'b0;
      addr_q      <= 5'd0;
      data_q      <= 32'd0;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_rd_q   <= skid_rd_d;
      skid_data_q <= skid_data_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

`ifndef SYNTHESIS
  // Upstream must hold ALU results whose destination still awaits a load.
  a_alu_raw: assert property (@(posedge clock) disable iff (reset)
    alu_acc |-> !busy_q[alu_rd_addr_i]);
`endif

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
module tb_riscv_wb_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid_i, alu_ready_o;
  logic [4:0]  alu_rd_addr_i;
  logic [31:0] alu_rd_data_i;
  logic        ld_issue_i, ld_issue_ready_o;
  logic [4:0]  ld_issue_rd_i;
  logic        ld_rsp_valid_i;
  logic [4:0]  ld_rsp_rd_i;
  logic [31:0] ld_rsp_data_i;
  logic [2:0]  ld_rsp_funct3_i;
  logic [1:0]  ld_rsp_addr_lo_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic        rs1_busy_o, rs2_busy_o;
  logic [2:0]  pending_o;
  logic        rd_wen_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  riscv_wb_arbiter dut (
    .clock(clock), .reset(reset),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_rd_addr_i(alu_rd_addr_i), .alu_rd_data_i(alu_rd_data_i),
    .ld_issue_i(ld_issue_i), .ld_issue_ready_o(ld_issue_ready_o), .ld_issue_rd_i(ld_issue_rd_i),
    .ld_rsp_valid_i(ld_rsp_valid_i), .ld_rsp_rd_i(ld_rsp_rd_i), .ld_rsp_data_i(ld_rsp_data_i),
    .ld_rsp_funct3_i(ld_rsp_funct3_i), .ld_rsp_addr_lo_i(ld_rsp_addr_lo_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o), .pending_o(pending_o),
    .rd_wen_o(rd_wen_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every register-file write must match the oldest expectation, in the
  // cycle it was expected.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (rd_wen_o) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL wb_unexpected: got x%0d=%h at cycle %0d, expected no write",
                   rd_addr_o, rd_data_o, cyc);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.a != rd_addr_o || e.d != rd_data_o) begin
            bad++;
            $display("FAIL wb: got x%0d=%h at cycle %0d, expected x%0d=%h at cycle %0d",
                     rd_addr_o, rd_data_o, cyc, e.a, e.d, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic push(input int lat, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = cyc + lat;
    e.a   = a;
    e.d   = d;
    q.push_back(e);
  endtask

  task automatic idle();
    alu_valid_i = 0; ld_issue_i = 0; ld_rsp_valid_i = 0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    alu_valid_i = 1; alu_rd_addr_i = a; alu_rd_data_i = d;
  endtask

  task automatic rsp(input logic [4:0] a, input logic [2:0] f3, input logic [1:0] lo,
                     input logic [31:0] w);
    ld_rsp_valid_i = 1; ld_rsp_rd_i = a; ld_rsp_funct3_i = f3;
    ld_rsp_addr_lo_i = lo; ld_rsp_data_i = w;
  endtask

  task automatic issue(input logic [4:0] a);
    ld_issue_i = 1; ld_issue_rd_i = a;
  endtask

  initial begin
    reset = 1;
    idle();
    alu_rd_addr_i = 0; alu_rd_data_i = 0; ld_issue_rd_i = 0; ld_rsp_rd_i = 0;
    ld_rsp_data_i = 0; ld_rsp_funct3_i = 0; ld_rsp_addr_lo_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0;
    repeat (2) neg();
    chk("rst_wen", rd_wen_o, 0);
    chk("rst_addr", rd_addr_o, 0);
    chk("rst_data", rd_data_o, 0);
    chk("rst_pend", pending_o, 0);
    chk("rst_alu_rdy", alu_ready_o, 1);
    chk("rst_iss_rdy", ld_issue_ready_o, 1);
    tick();
    reset = 0;

    // Lone ALU result, one-cycle latency.
    alu(5, 32'h1234); push(1, 5, 32'h1234);
    tick(); idle();

    // Collision: load wins, ALU drains from the skid next cycle.
    tick();
    rsp(3, 3'b010, 0, 32'hDEADBEEF); push(1, 3, 32'hDEADBEEF);
    alu(7, 32'h11); push(2, 7, 32'h11);
    neg(); chk("col_rdy0", alu_ready_o, 1);
    tick(); idle();
    neg(); chk("col_rdy1", alu_ready_o, 0);
    tick();
    neg(); chk("col_rdy2", alu_ready_o, 1);
    chk("col_pend_nounderflow", pending_o, 0);

    // Skid held while a second response arrives; offered ALU result not taken.
    tick();
    rsp(10, 3'b010, 0, 32'hA0A0); push(1, 10, 32'hA0A0);
    alu(11, 32'hB1);
    tick();
    rsp(12, 3'b010, 0, 32'hC2); push(1, 12, 32'hC2); push(2, 11, 32'hB1);
    alu(13, 32'hD3);
    neg(); chk("skid_hold_rdy", alu_ready_o, 0);
    tick(); idle();
    tick();

    // Load formatting on 0x80FF7F01.
    tick(); rsp(1, 3'b000, 3, 32'h80FF7F01); push(1, 1, 32'hFFFFFF80);
    tick(); rsp(2, 3'b100, 1, 32'h80FF7F01); push(1, 2, 32'h0000007F);
    tick(); rsp(4, 3'b001, 2, 32'h80FF7F01); push(1, 4, 32'hFFFF80FF);
    tick(); rsp(6, 3'b101, 0, 32'h80FF7F01); push(1, 6, 32'h00007F01);
    tick(); rsp(8, 3'b011, 0, 32'h80FF7F01); push(1, 8, 32'h80FF7F01);
    tick(); rsp(14, 3'b001, 3, 32'h80FF7F01); push(1, 14, 32'hFFFF80FF);
    tick(); idle();

    // rd=0 ALU: handshake completes, no write.
    tick(); alu(0, 32'h55);
    neg(); chk("x0_rdy", alu_ready_o, 1);
    tick(); idle();
    neg(); chk("x0_nowen", rd_wen_o, 0);

    // Scoreboard set/clear.
    tick(); issue(9); rs1_addr_i = 9; rs2_addr_i = 9;
    neg(); chk("sb_busy_pre", rs1_busy_o, 0);
    tick(); idle();
    neg(); chk("sb_busy1", rs1_busy_o, 1); chk("sb_busy2", rs2_busy_o, 1);
    chk("sb_pend1", pending_o, 1);
    tick(); rsp(9, 3'b010, 0, 32'hCAFE0000); push(1, 9, 32'hCAFE0000);
    neg(); chk("sb_busy_rsp", rs1_busy_o, 1);
    tick(); idle();
    neg(); chk("sb_clear", rs1_busy_o, 0); chk("sb_pend0", pending_o, 0);
    tick(); issue(0); rs1_addr_i = 0;
    tick(); idle();
    neg(); chk("x0_issue_pend", pending_o, 1); chk("x0_issue_busy", rs1_busy_o, 0);
    tick(); rsp(0, 3'b010, 0, 32'h1);
    tick(); idle();
    neg(); chk("x0_rsp_pend", pending_o, 0);

    // Same-cycle issue and response on one rd: set wins, count unchanged.
    tick(); issue(20); rs1_addr_i = 20;
    tick(); idle(); issue(20); rsp(20, 3'b010, 0, 32'h20); push(1, 20, 32'h20);
    tick(); idle();
    neg(); chk("same_busy", rs1_busy_o, 1); chk("same_pend", pending_o, 1);
    tick(); rsp(20, 3'b010, 0, 32'h21); push(1, 20, 32'h21);
    tick(); idle();
    neg(); chk("same_clear", rs1_busy_o, 0); chk("same_pend0", pending_o, 0);

    // Pending limit.
    tick(); issue(21);
    tick(); issue(22);
    tick(); issue(23);
    tick(); issue(24);
    tick(); issue(25); rs1_addr_i = 25;
    neg(); chk("lim_rdy0", ld_issue_ready_o, 0); chk("lim_pend4", pending_o, 4);
    tick(); idle();
    neg(); chk("lim_pend_hold", pending_o, 4); chk("lim_5th_busy", rs1_busy_o, 0);
    tick(); rsp(21, 3'b010, 0, 32'h21E); push(1, 21, 32'h21E);
    tick(); idle();
    neg(); chk("lim_pend3", pending_o, 3); chk("lim_rdy1", ld_issue_ready_o, 1);
    tick(); issue(25); rsp(22, 3'b010, 0, 32'h22E); push(1, 22, 32'h22E); rs2_addr_i = 22;
    tick(); idle();
    neg(); chk("both_pend3", pending_o, 3); chk("both_busy25", rs1_busy_o, 1);
    chk("both_clr22", rs2_busy_o, 0);

    // Reset with skid full and two loads (24, 25) outstanding.
    tick(); rsp(23, 3'b010, 0, 32'h23E); push(1, 23, 32'h23E); alu(26, 32'h26);
    tick(); idle(); rs1_addr_i = 24; rs2_addr_i = 25;
    neg();
    chk("pre_rst_pend", pending_o, 2);
    chk("pre_rst_skid", alu_ready_o, 0);
    #1 reset = 1;
    #1;
    chk("mrst_wen", rd_wen_o, 0); chk("mrst_addr", rd_addr_o, 0); chk("mrst_data", rd_data_o, 0);
    chk("mrst_pend", pending_o, 0); chk("mrst_busy1", rs1_busy_o, 0);
    chk("mrst_busy2", rs2_busy_o, 0); chk("mrst_alu_rdy", alu_ready_o, 1);
    chk("mrst_iss_rdy", ld_issue_ready_o, 1);
    tick(); reset = 0;
    neg(); chk("post_rst_noskid", rd_wen_o, 0);
    tick(); rsp(24, 3'b100, 0, 32'h000000AB); push(1, 24, 32'h000000AB);
    tick(); idle();
    neg(); chk("late_rsp_pend", pending_o, 0);

    repeat (3) tick();
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
